// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle RV64-subset sequencer.
package mc_pkg;

    // One state per instruction phase; TRAP is terminal until reset.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_WB_LD    = 4'd6,
        S_MEM_WR   = 4'd7,
        S_BRANCH   = 4'd8,
        S_TRAP     = 4'd9
    } mc_state_t;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_SD    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RS2     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH1 = 2'b11;

    // Full set of datapath controls driven by the sequencer.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_source;
        logic       illegal_op;
    } mc_ctrl_t;

endpackage

// File: rtl/mc_retire_counter.sv
// Wrapping retired-instruction counter.
module mc_retire_counter
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    // Count one per retire; natural overflow gives the wrap to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   count_q <= '0;
        else if (inc) count_q <= count_q + CNT_W'(1);
    end

    assign count = count_q;

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer for the multi-cycle RV64 subset datapath (R, ld, sd, beq).
module multicycle_control
    import mc_pkg::*;
#(
    parameter int width_instruc = 7,
    parameter int CNT_W         = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [width_instruc-1:0] opcode,
    input  logic                     zero,
    input  logic                     mem_ready,
    output logic                     PCWrite,
    output logic                     PCWriteCond,
    output logic                     IorD,
    output logic                     IRWrite,
    output logic                     MemRead,
    output logic                     MemWrite,
    output logic                     MemtoReg,
    output logic                     RegWrite,
    output logic                     ALUSrcA,
    output logic [1:0]               ALUSrcB,
    output logic [1:0]               ALUOp,
    output logic                     PCSource,
    output logic                     illegal_op,
    output logic [CNT_W-1:0]         instr_count
);

    mc_state_t state_q, state_d;
    mc_ctrl_t  ctrl;
    logic      run_q;
    logic      retire;

    // The branch decision (PCWriteCond & zero) is formed in the datapath.
    logic unused_zero;
    assign unused_zero = zero;

    // Cleared asynchronously by reset, set on the first edge after release:
    // holds every output at 0 and freezes the FSM until then, so the first
    // fetch request shows up in the cycle after rst_n deasserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_q <= 1'b0;
        else        run_q <= 1'b1;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next-state and retire decode.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        if (run_q) begin
            case (state_q)
                S_FETCH: if (mem_ready) state_d = S_DECODE;
                S_DECODE: begin
                    if (opcode == width_instruc'(OP_RTYPE))
                        state_d = S_EXEC_R;
                    else if (opcode == width_instruc'(OP_LD) ||
                             opcode == width_instruc'(OP_SD))
                        state_d = S_MEM_ADDR;
                    else if (opcode == width_instruc'(OP_BEQ))
                        state_d = S_BRANCH;
                    else
                        state_d = S_TRAP;
                end
                S_EXEC_R: state_d = S_WB_R;
                S_WB_R: begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
                // IR is stable here; anything but ld/sd means it was corrupted.
                S_MEM_ADDR: begin
                    if (opcode == width_instruc'(OP_LD))      state_d = S_MEM_RD;
                    else if (opcode == width_instruc'(OP_SD)) state_d = S_MEM_WR;
                    else                                      state_d = S_TRAP;
                end
                S_MEM_RD: if (mem_ready) state_d = S_WB_LD;
                S_WB_LD: begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
                S_MEM_WR: begin
                    if (mem_ready) begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                end
                S_BRANCH: begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
                S_TRAP:  state_d = S_TRAP;
                default: state_d = S_FETCH;
            endcase
        end
    end

    // Output decode from state; only IRWrite/PCWrite also look at mem_ready.
    always_comb begin
        ctrl = '0;
        if (run_q) begin
            case (state_q)
                S_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.alu_op    = ALUOP_ADD;
                    ctrl.ir_write  = mem_ready;
                    ctrl.pc_write  = mem_ready;
                end
                S_DECODE: begin
                    ctrl.alu_src_b = SRCB_IMM_SH1;
                    ctrl.alu_op    = ALUOP_ADD;
                end
                S_EXEC_R: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_RS2;
                    ctrl.alu_op    = ALUOP_FUNCT;
                end
                S_WB_R: ctrl.reg_write = 1'b1;
                S_MEM_ADDR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALUOP_ADD;
                end
                S_MEM_RD: begin
                    ctrl.i_or_d   = 1'b1;
                    ctrl.mem_read = 1'b1;
                end
                S_WB_LD: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end
                S_MEM_WR: begin
                    ctrl.i_or_d    = 1'b1;
                    ctrl.mem_write = 1'b1;
                end
                S_BRANCH: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = SRCB_RS2;
                    ctrl.alu_op        = ALUOP_SUB;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = 1'b1;
                end
                S_TRAP:  ctrl.illegal_op = 1'b1;
                default: ctrl = '0;
            endcase
        end
    end

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign IRWrite     = ctrl.ir_write;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign illegal_op  = ctrl.illegal_op;

    mc_retire_counter #(.CNT_W(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire),
        .count (instr_count)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: stimulus pushes per-cycle expected controls, monitor checks.
module tb_multicycle_control;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    opcode = 7'd0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite;
    logic          MemtoReg, RegWrite, ALUSrcA, PCSource, illegal_op;
    logic [1:0]    ALUSrcB, ALUOp;
    logic [CW-1:0] instr_count;

    multicycle_control #(.width_instruc(7), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .IRWrite(IRWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .illegal_op(illegal_op), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Bit order: PCWrite PCWriteCond IorD IRWrite MemRead MemWrite MemtoReg
    //            RegWrite ALUSrcA ALUSrcB[1:0] ALUOp[1:0] PCSource illegal_op
    function automatic logic [14:0] ctl(input logic pcw, pcwc, iord, irw, mr, mw, m2r, rw, sa,
                                        input logic [1:0] sb, op, input logic ps, ill);
        return {pcw, pcwc, iord, irw, mr, mw, m2r, rw, sa, sb, op, ps, ill};
    endfunction

    localparam logic [14:0] E_ZERO = 15'd0;
    localparam logic [14:0] E_FW   = ctl(0,0,0,0,1,0,0,0,0,2'b01,2'b00,0,0);
    localparam logic [14:0] E_FR   = ctl(1,0,0,1,1,0,0,0,0,2'b01,2'b00,0,0);
    localparam logic [14:0] E_DEC  = ctl(0,0,0,0,0,0,0,0,0,2'b11,2'b00,0,0);
    localparam logic [14:0] E_EXR  = ctl(0,0,0,0,0,0,0,0,1,2'b00,2'b10,0,0);
    localparam logic [14:0] E_WBR  = ctl(0,0,0,0,0,0,0,1,0,2'b00,2'b00,0,0);
    localparam logic [14:0] E_MA   = ctl(0,0,0,0,0,0,0,0,1,2'b10,2'b00,0,0);
    localparam logic [14:0] E_MRD  = ctl(0,0,1,0,1,0,0,0,0,2'b00,2'b00,0,0);
    localparam logic [14:0] E_WBLD = ctl(0,0,0,0,0,0,1,1,0,2'b00,2'b00,0,0);
    localparam logic [14:0] E_MWR  = ctl(0,0,1,0,0,1,0,0,0,2'b00,2'b00,0,0);
    localparam logic [14:0] E_BR   = ctl(0,1,0,0,0,0,0,0,1,2'b00,2'b01,1,0);
    localparam logic [14:0] E_TRAP = ctl(0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,1);

    localparam logic [6:0] O_R   = 7'b0110011;
    localparam logic [6:0] O_LD  = 7'b0000011;
    localparam logic [6:0] O_SD  = 7'b0100011;
    localparam logic [6:0] O_BEQ = 7'b1100011;
    localparam logic [6:0] O_ILL = 7'b1110011;

    typedef struct {
        logic [14:0]   ctl;
        logic [CW-1:0] cnt;
        int            id;
    } exp_t;

    exp_t          q[$];
    int            n_vec = 0;
    int            n_bad = 0;
    int            sid = 0;
    logic [CW-1:0] exp_cnt = '0;

    wire [14:0] act = {PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemtoReg,
                       RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};

    // One cycle: drive inputs just after the edge, record what that cycle must show.
    task automatic step(input logic rst, input logic [6:0] op, input logic rdy, z,
                        input logic [14:0] e, input logic ret);
        exp_t x;
        @(posedge clk); #1;
        rst_n = rst; opcode = op; mem_ready = rdy; zero = z;
        if (!rst) exp_cnt = '0;
        x.ctl = e; x.cnt = exp_cnt; x.id = sid;
        q.push_back(x);
        sid++;
        if (ret) exp_cnt = exp_cnt + 1'b1;
    endtask

    // Opcode is scrambled in EXEC_R/WB_R: it must not matter there.
    task automatic do_r();
        step(1, O_R, 1, 0, E_FR, 0);
        step(1, O_R, 1, 0, E_DEC, 0);
        step(1, O_ILL, 1, 0, E_EXR, 0);
        step(1, 7'h00, 0, 0, E_WBR, 1);
    endtask

    task automatic do_ld(input int waits);
        step(1, O_LD, 1, 0, E_FR, 0);
        step(1, O_LD, 1, 0, E_DEC, 0);
        step(1, O_LD, 1, 0, E_MA, 0);
        for (int i = 0; i < waits; i++) step(1, O_LD, 0, 0, E_MRD, 0);
        step(1, O_LD, 1, 0, E_MRD, 0);
        step(1, O_LD, 1, 0, E_WBLD, 1);
    endtask

    task automatic do_sd();
        step(1, O_SD, 1, 0, E_FR, 0);
        step(1, O_SD, 1, 0, E_DEC, 0);
        step(1, O_SD, 1, 0, E_MA, 0);
        step(1, O_SD, 1, 0, E_MWR, 1);
    endtask

    task automatic do_beq(input logic z);
        step(1, O_BEQ, 1, 0, E_FR, 0);
        step(1, O_BEQ, 1, 0, E_DEC, 0);
        step(1, O_BEQ, 1, z, E_BR, 1);
    endtask

    // Monitor: every cycle with a pending expectation is checked mid-cycle.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                n_vec++;
                if (act !== x.ctl) begin
                    n_bad++;
                    $display("FAIL ctrl step %0d: got %b expected %b", x.id, act, x.ctl);
                end
                n_vec++;
                if (instr_count !== x.cnt) begin
                    n_bad++;
                    $display("FAIL instr_count step %0d: got %0d expected %0d",
                             x.id, instr_count, x.cnt);
                end
            end
        end
    end

    initial begin
        int guard;
        // Reset held; mem_ready high in the second cycle must be ignored.
        step(0, 7'h00, 0, 0, E_ZERO, 0);
        step(0, 7'h00, 1, 0, E_ZERO, 0);
        // Release: outputs stay 0 this cycle, fetch appears next.
        step(1, 7'h00, 0, 0, E_ZERO, 0);
        step(1, O_R, 0, 0, E_FW, 0);
        do_r();
        do_ld(3);
        do_beq(1'b1);
        do_beq(1'b0);
        do_sd();
        // Illegal opcode: sticky trap, count frozen at 5.
        step(1, O_ILL, 1, 0, E_FR, 0);
        step(1, O_ILL, 1, 0, E_DEC, 0);
        for (int i = 0; i < 11; i++) step(1, O_R, i[0], 0, E_TRAP, 0);
        step(0, O_R, 1, 0, E_ZERO, 0);
        step(1, O_R, 1, 0, E_ZERO, 0);
        do_r();
        // Reset lands in MEM_WR: all outputs drop, the store is not counted.
        step(1, O_SD, 1, 0, E_FR, 0);
        step(1, O_SD, 1, 0, E_DEC, 0);
        step(1, O_SD, 1, 0, E_MA, 0);
        step(1, O_SD, 0, 0, E_MWR, 0);
        step(0, O_SD, 1, 0, E_ZERO, 0);
        step(1, O_SD, 1, 0, E_ZERO, 0);
        step(1, O_SD, 0, 0, E_FW, 0);
        // 16 stores on a 4-bit counter: the last retire wraps to 0.
        for (int i = 0; i < 16; i++) do_sd();
        step(1, O_R, 0, 0, E_FW, 0);

        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
